// File: rtl/regdst_writeback.sv
// One-entry buffered register-file writeback with destination decode and a commit counter.
// Optional read bypass of the buffered entry is enabled by defining REGDST_WB_BYPASS_EN.
module regdst_writeback #(
  parameter logic [31:0] SP_RESET = 32'd227
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic        wb_hold,
  input  logic [1:0]  wb_sel,
  input  logic [4:0]  wb_rt,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic [4:0]  rd_addr_a,
  input  logic [4:0]  rd_addr_b,
  output logic [31:0] rd_data_a,
  output logic [31:0] rd_data_b,
  output logic [15:0] commit_cnt
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t      state;
  logic        buf_valid;
  logic [4:0]  buf_idx;
  logic [31:0] buf_data;
  logic [31:0] bank [32];

  logic [4:0]  dest_idx;
  logic        accept;
  logic        commit;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    dest_idx = wb_rt;
    case (wb_sel)
      2'd0: dest_idx = wb_rt;
      2'd1: dest_idx = wb_rd;
      2'd2: dest_idx = 5'd31;
      2'd3: dest_idx = 5'd29;
      default: dest_idx = wb_rt;
    endcase
  end

  // A full buffer drains on any unheld cycle, which is also what frees room for a new request.
  assign wb_ready = (state == IDLE) || !wb_hold;
  assign accept   = wb_valid && wb_ready;
  assign commit   = buf_valid && !wb_hold;

  // NOTE: the bank is reset explicitly because register 29 has a defined non-zero reset value
  // and every other entry must read 0 right after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      buf_valid  <= 1'b0;
      buf_idx    <= '0;
      buf_data   <= '0;
      commit_cnt <= '0;
      for (int i = 0; i < 32; i++) begin
        bank[i] <= (i == 29) ? SP_RESET : '0;
      end
    end else begin
      // NOTE: non-blocking assignments let the old entry commit while the new one loads on the same edge.
      if (commit && (buf_idx != 5'd0)) begin
        bank[buf_idx] <= buf_data;
        commit_cnt    <= commit_cnt + 16'd1;
      end
      if (accept) begin
        state     <= PEND;
        buf_valid <= 1'b1;
        buf_idx   <= dest_idx;
        buf_data  <= wb_data;
      end else if (commit) begin
        state     <= IDLE;
        buf_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data_a = (rd_addr_a == 5'd0) ? 32'd0 : bank[rd_addr_a];
    rd_data_b = (rd_addr_b == 5'd0) ? 32'd0 : bank[rd_addr_b];
`ifdef REGDST_WB_BYPASS_EN
    if (buf_valid && (rd_addr_a != 5'd0) && (rd_addr_a == buf_idx)) rd_data_a = buf_data;
    if (buf_valid && (rd_addr_b != 5'd0) && (rd_addr_b == buf_idx)) rd_data_b = buf_data;
`else
    // Without bypass the buffered value only becomes visible once it lands in the bank.
`endif
  end

endmodule

// File: tb/tb_regdst_writeback.sv
// Table-driven bench for regdst_writeback with a scoreboard of accepted writes.
// Expectations for port B follow REGDST_WB_BYPASS_EN when it is defined.
module tb_regdst_writeback;

  logic        clk;
  logic        reset;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_hold;
  logic [1:0]  wb_sel;
  logic [4:0]  wb_rt;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [15:0] commit_cnt;

  regdst_writeback #(.SP_RESET(32'd227)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_hold(wb_hold),
    .wb_sel(wb_sel), .wb_rt(wb_rt), .wb_rd(wb_rd), .wb_data(wb_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .commit_cnt(commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        h;
    logic [1:0]  sel;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  rb;
    logic        rdy;
    logic [31:0] b;
    logic [31:0] b_byp;
  } vec_t;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } sb_t;

  sb_t  q[$];
  int   total = 0;
  int   bad = 0;
  logic [15:0] exp_cnt = 16'd0;
  vec_t vecs [13];
  vec_t sp_vec;
  vec_t idle_vec;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic step(input vec_t t, input string name);
    sb_t  e;
    logic acc;
    logic com;
    @(negedge clk);
    wb_valid  = t.v;
    wb_hold   = t.h;
    wb_sel    = t.sel;
    wb_rt     = t.rt;
    wb_rd     = t.rd;
    wb_data   = t.data;
    rd_addr_b = t.rb;
    #1;
    check({name, " ready"}, {31'd0, wb_ready}, {31'd0, t.rdy});
    com = (q.size() > 0) && !t.h;
    acc = t.v && ((q.size() == 0) || !t.h);
    @(posedge clk);
    #1;
    if (com) begin
      e = q.pop_front();
      if (e.idx != 5'd0) exp_cnt++;
      rd_addr_a = e.idx;
      #1;
      check({name, " commit"}, rd_data_a, (e.idx == 5'd0) ? 32'd0 : e.data);
    end
    if (acc) begin
      case (t.sel)
        2'd0: e.idx = t.rt;
        2'd1: e.idx = t.rd;
        2'd2: e.idx = 5'd31;
        default: e.idx = 5'd29;
      endcase
      e.data = t.data;
      q.push_back(e);
    end
`ifdef REGDST_WB_BYPASS_EN
    check({name, " rd_b"}, rd_data_b, t.b_byp);
`else
    check({name, " rd_b"}, rd_data_b, t.b);
`endif
    check({name, " cnt"}, {16'd0, commit_cnt}, {16'd0, exp_cnt});
  endtask

  initial begin
    //             v  h  sel rt    rd    data            rb     rdy b              b_byp
    vecs[0]  = '{1'b1, 1'b0, 2'd1, 5'd0, 5'd8, 32'hDEADBEEF, 5'd8,  1'b1, 32'd0,        32'hDEADBEEF};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 32'd0,        5'd8,  1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b1, 2'd2, 5'd0, 5'd0, 32'h1234,     5'd31, 1'b1, 32'd0,        32'h1234};
    vecs[3]  = '{1'b1, 1'b1, 2'd0, 5'd7, 5'd0, 32'd55,       5'd31, 1'b0, 32'd0,        32'h1234};
    vecs[4]  = '{1'b0, 1'b1, 2'd0, 5'd0, 5'd0, 32'd0,        5'd31, 1'b0, 32'd0,        32'h1234};
    vecs[5]  = '{1'b0, 1'b1, 2'd0, 5'd0, 5'd0, 32'd0,        5'd31, 1'b0, 32'd0,        32'h1234};
    vecs[6]  = '{1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 32'd0,        5'd31, 1'b1, 32'h1234,     32'h1234};
    vecs[7]  = '{1'b1, 1'b0, 2'd0, 5'd3, 5'd0, 32'd1,        5'd3,  1'b1, 32'd0,        32'd1};
    vecs[8]  = '{1'b1, 1'b0, 2'd0, 5'd4, 5'd0, 32'd2,        5'd3,  1'b1, 32'd1,        32'd1};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 32'd0,        5'd4,  1'b1, 32'd2,        32'd2};
    vecs[10] = '{1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 5'd0,  1'b1, 32'd0,        32'd0};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 32'd0,        5'd0,  1'b1, 32'd0,        32'd0};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 32'd0,        5'd7,  1'b1, 32'd0,        32'd0};
    sp_vec   = '{1'b1, 1'b0, 2'd3, 5'd0, 5'd0, 32'd99,       5'd29, 1'b1, 32'd227,      32'd99};
    idle_vec = '{1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 32'd0,        5'd29, 1'b1, 32'd227,      32'd227};

    reset = 1'b0;
    wb_valid = 1'b0; wb_hold = 1'b0; wb_sel = 2'd0;
    wb_rt = 5'd0; wb_rd = 5'd0; wb_data = 32'd0;
    rd_addr_a = 5'd29; rd_addr_b = 5'd5;
    repeat (2) @(posedge clk);
    #1;
    check("in_reset ready", {31'd0, wb_ready}, 32'd1);
    check("in_reset r29", rd_data_a, 32'd227);
    check("in_reset r5", rd_data_b, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_reset ready", {31'd0, wb_ready}, 32'd1);
    check("post_reset r29", rd_data_a, 32'd227);
    check("post_reset r5", rd_data_b, 32'd0);
    check("post_reset cnt", {16'd0, commit_cnt}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end
    check("after_table cnt", {16'd0, commit_cnt}, 32'd4);

    // Buffered write to r29 dropped by a mid-operation reset.
    step(sp_vec, "sp_accept");
    #2;
    reset = 1'b0;
    q.delete();
    exp_cnt = 16'd0;
    rd_addr_a = 5'd29;
    #1;
    check("mid_reset r29", rd_data_a, 32'd227);
    check("mid_reset cnt", {16'd0, commit_cnt}, 32'd0);
    check("mid_reset ready", {31'd0, wb_ready}, 32'd1);
    rd_addr_a = 5'd8;
    #1;
    check("mid_reset r8 cleared", rd_data_a, 32'd0);
    @(posedge clk);
    @(negedge clk);
    wb_valid = 1'b0;
    reset = 1'b1;
    step(idle_vec, "after_reset idle");
    rd_addr_a = 5'd29;
    #1;
    check("after_reset r29", rd_data_a, 32'd227);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
